// File: rtl/axi_txn_sequencer_if.sv
// Bundle of start/enable controls, per-port engine handshake lines and sequence status
// exchanged between the AXI transaction sequencer (slave) and whatever drives it (master).
interface axi_txn_sequencer_if #(
   parameter int NUM_CH = 2
);
   logic              start;
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] init_o;
   logic [NUM_CH-1:0] done_i;
   logic [NUM_CH-1:0] error_i;
   logic              busy;
   logic              seq_done;
   logic              pass;
   logic [NUM_CH-1:0] fail_mask;
   logic [NUM_CH-1:0] timeout_mask;

   modport master (
      output start, ch_en, done_i, error_i,
      input  init_o, busy, seq_done, pass, fail_mask, timeout_mask
   );

   modport slave (
      input  start, ch_en, done_i, error_i,
      output init_o, busy, seq_done, pass, fail_mask, timeout_mask
   );
endinterface

// File: rtl/axi_txn_sequencer.sv
// Runs each enabled AXI master test engine in turn (gap, init pulse, wait for done) and
// reports per-port fail/timeout masks plus a pass flag. Define AXI_SEQ_TIMEOUT_EN for WAIT timeouts.
module axi_txn_sequencer #(
   parameter int NUM_CH         = 2,
   parameter int GAP_CYCLES     = 20,
   parameter int PULSE_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   axi_txn_sequencer_if.slave   bus
);

   localparam int CNT_MAX_V = (GAP_CYCLES > PULSE_CYCLES)
                              ? ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES)
                              : ((PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES);
   localparam int CNT_W = $clog2(CNT_MAX_V + 1);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX_V);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
`ifdef AXI_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_GAP,
      S_PULSE,
      S_WAIT,
      S_NEXT,
      S_FINISH
   } state_e;

   state_e            state_q;
   logic [CH_W-1:0]   ch_q;
   logic [NUM_CH-1:0] en_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [NUM_CH-1:0] init_q;
   logic              busy_q;
   logic              seq_done_q;
   logic              pass_q;
   logic [NUM_CH-1:0] fail_q;
   logic [NUM_CH-1:0] timeout_q;

   logic [CH_W-1:0]   first_ch_d;
   logic              first_vld_d;
   logic [CH_W-1:0]   next_ch_d;
   logic              next_vld_d;
   logic [CNT_W-1:0]  cnt_inc_d;

   function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
      ch_onehot      = '0;
      ch_onehot[idx] = 1'b1;
   endfunction

   // Scanning downwards lets the lowest enabled index win.
   always_comb begin
      first_vld_d = 1'b0;
      first_ch_d  = '0;
      next_vld_d  = 1'b0;
      next_ch_d   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (bus.ch_en[i]) begin
            first_vld_d = 1'b1;
            first_ch_d  = CH_W'(i);
         end
         if (en_q[i] && (i > int'(ch_q))) begin
            next_vld_d = 1'b1;
            next_ch_d  = CH_W'(i);
         end
      end
   end

   assign cnt_inc_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

   // NOTE: every register here, including the masks, is cleared by the synchronous reset and
   // updated with non-blocking assignments so all state advances together on the clock edge.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         en_q       <= '0;
         cnt_q      <= '0;
         init_q     <= '0;
         busy_q     <= 1'b0;
         seq_done_q <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= '0;
         timeout_q  <= '0;
      end else begin
         seq_done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  en_q      <= bus.ch_en;
                  fail_q    <= '0;
                  timeout_q <= '0;
                  pass_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  ch_q      <= first_ch_d;
                  if (!first_vld_d) begin
                     state_q <= S_FINISH;
                  end else if (GAP_CYCLES == 0) begin
                     state_q <= S_PULSE;
                     init_q  <= ch_onehot(first_ch_d);
                  end else begin
                     state_q <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_q <= S_PULSE;
                  cnt_q   <= '0;
                  init_q  <= ch_onehot(ch_q);
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
            S_PULSE: begin
               if (cnt_q == PULSE_LAST) begin
                  state_q <= S_WAIT;
                  cnt_q   <= '0;
                  init_q  <= '0;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
            S_WAIT: begin
               if (bus.done_i[ch_q]) begin
                  fail_q[ch_q] <= bus.error_i[ch_q];
                  state_q      <= S_NEXT;
`ifdef AXI_SEQ_TIMEOUT_EN
               end else if (cnt_q == TO_LAST) begin
                  timeout_q[ch_q] <= 1'b1;
                  fail_q[ch_q]    <= 1'b1;
                  state_q         <= S_NEXT;
               end else begin
                  cnt_q <= cnt_inc_d;
`endif
               end
            end
            S_NEXT: begin
               cnt_q <= '0;
               if (next_vld_d) begin
                  ch_q <= next_ch_d;
                  if (GAP_CYCLES == 0) begin
                     state_q <= S_PULSE;
                     init_q  <= ch_onehot(next_ch_d);
                  end else begin
                     state_q <= S_GAP;
                  end
               end else begin
                  state_q <= S_FINISH;
               end
            end
            S_FINISH: begin
               seq_done_q <= 1'b1;
               pass_q     <= ~|fail_q;
               busy_q     <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.init_o       = init_q;
   assign bus.busy         = busy_q;
   assign bus.seq_done     = seq_done_q;
   assign bus.pass         = pass_q;
   assign bus.fail_mask    = fail_q;
`ifdef AXI_SEQ_TIMEOUT_EN
   assign bus.timeout_mask = timeout_q;
`else
   assign bus.timeout_mask = '0;
`endif

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Directed bench for axi_txn_sequencer: behavioural AXI test engines per port, a scoreboard of
// expected sequence results, and a monitor that checks each seq_done against it.
module tb_axi_txn_sequencer;

   localparam int NUM_CH = 2;
   localparam int GAP    = 20;
   localparam int PULSE  = 2;
   localparam int TMO    = 100;
   localparam int LAT    = 50;

   typedef struct {
      logic [NUM_CH-1:0] fail;
      logic [NUM_CH-1:0] tmo;
      logic              pass;
   } exp_t;

   logic ACLK = 1'b0;
   logic ARESET;

   axi_txn_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

   axi_txn_sequencer #(
      .NUM_CH         (NUM_CH),
      .GAP_CYCLES     (GAP),
      .PULSE_CYCLES   (PULSE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int start_cyc;
   int done_count = 0;
   int done_cyc   = 0;
   exp_t sb[$];

   logic [NUM_CH-1:0] err_cfg;
   logic [NUM_CH-1:0] hang;
   logic [NUM_CH-1:0] init_prev;
   int  dcnt[NUM_CH];
   bit  armed[NUM_CH];
   int  rise_cyc[NUM_CH];
   int  width[NUM_CH];
   int  pulses[NUM_CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge ACLK) cyc++;

   // Behavioural test engine: init clears done; done (with configured error) follows LAT cycles later.
   always @(negedge ACLK) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (ARESET) begin
            bus.done_i[i]  = 1'b0;
            bus.error_i[i] = 1'b0;
            armed[i]       = 1'b0;
         end else if (bus.init_o[i] && !init_prev[i]) begin
            bus.done_i[i]  = 1'b0;
            bus.error_i[i] = 1'b0;
            armed[i]       = 1'b1;
            dcnt[i]        = LAT;
            rise_cyc[i]    = cyc;
            width[i]       = 1;
            pulses[i]++;
         end else begin
            if (bus.init_o[i]) width[i]++;
            if (armed[i] && !hang[i]) begin
               dcnt[i]--;
               if (dcnt[i] == 0) begin
                  bus.done_i[i]  = 1'b1;
                  bus.error_i[i] = err_cfg[i];
                  armed[i]       = 1'b0;
               end
            end
         end
      end
      init_prev = bus.init_o;
   end

   // Monitor: one-hot init and scoreboard comparison on every seq_done.
   always @(negedge ACLK) begin
      exp_t e;
      if (bus.init_o != '0) check("init_onehot", $countones(bus.init_o), 1);
      if (bus.seq_done) begin
         done_count++;
         done_cyc = cyc;
         check("sb_pending", (sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("fail_mask", bus.fail_mask, e.fail);
            check("timeout_mask", bus.timeout_mask, e.tmo);
            check("pass", bus.pass, e.pass);
         end
      end
   end

   task automatic do_start(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] fail,
                           input logic [NUM_CH-1:0] tmo, input logic pass);
      exp_t e;
      @(negedge ACLK);
      bus.ch_en = en;
      bus.start = 1'b1;
      start_cyc = cyc;
      e.fail = fail;
      e.tmo  = tmo;
      e.pass = pass;
      sb.push_back(e);
      @(negedge ACLK);
      bus.start = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge ACLK);
      bus.start = 1'b1;
      @(negedge ACLK);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int base;
      base = done_count;
      for (int k = 0; k < budget; k++) begin
         @(posedge ACLK);
         if (done_count != base) break;
      end
      check("seq_done_seen", (done_count != base), 1);
      @(negedge ACLK);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge ACLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int p1;
      int dc;
      ARESET    = 1'b1;
      bus.start = 1'b0;
      bus.ch_en = '0;
      err_cfg   = '0;
      hang      = '0;
      repeat (3) @(negedge ACLK);
      check("rst_init", bus.init_o, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_seq_done", bus.seq_done, 0);
      check("rst_pass", bus.pass, 0);
      check("rst_fail", bus.fail_mask, 0);
      check("rst_tmo", bus.timeout_mask, 0);
      ARESET = 1'b0;
      repeat (2) @(negedge ACLK);

      // Both ports, no errors
      do_start(2'b11, 2'b00, 2'b00, 1'b1);
      check("t1_busy", bus.busy, 1);
      wait_done(600);
      check("t1_rise0", rise_cyc[0] - start_cyc, 21);
      check("t1_width0", width[0], PULSE);
      check("t1_rise1", rise_cyc[1] - start_cyc, 93);
      check("t1_width1", width[1], PULSE);
      check("t1_done_cyc", done_cyc - start_cyc, 146);
      check("t1_busy_end", bus.busy, 0);

      // Error on port 1
      err_cfg = 2'b10;
      do_start(2'b11, 2'b10, 2'b00, 1'b0);
      wait_done(600);
      repeat (5) @(negedge ACLK);
      check("t2_pass_held", bus.pass, 0);

      // Port 0 disabled; its configured error must not matter
      err_cfg = 2'b01;
      p0 = pulses[0];
      p1 = pulses[1];
      do_start(2'b10, 2'b00, 2'b00, 1'b1);
      wait_done(600);
      check("t3_no_pulse0", pulses[0] - p0, 0);
      check("t3_pulse1", pulses[1] - p1, 1);
      check("t3_rise1", rise_cyc[1] - start_cyc, 21);

      // No ports enabled
      err_cfg = 2'b00;
      do_start(2'b00, 2'b00, 2'b00, 1'b1);
      wait_done(50);
      check("t3_empty_done_cyc", done_cyc - start_cyc, 2);

`ifdef AXI_SEQ_TIMEOUT_EN
      // Port 0 never completes
      hang = 2'b01;
      do_start(2'b11, 2'b01, 2'b01, 1'b0);
      wait_done(800);
      check("t4_rise1", rise_cyc[1] - start_cyc, 144);
      hang = 2'b00;
`endif

      // Reset during WAIT of port 0 aborts the sequence
      dc = done_count;
      do_start(2'b11, 2'b00, 2'b00, 1'b1);
      wait_until(start_cyc + 30);
      ARESET = 1'b1;
      @(negedge ACLK);
      @(negedge ACLK);
      sb.delete();
      check("t5_init", bus.init_o, 0);
      check("t5_busy", bus.busy, 0);
      check("t5_seq_done", bus.seq_done, 0);
      ARESET = 1'b0;
      repeat (100) @(negedge ACLK);
      check("t5_no_seq_done", done_count - dc, 0);
      do_start(2'b11, 2'b00, 2'b00, 1'b1);
      wait_done(600);
      check("t5_rise0", rise_cyc[0] - start_cyc, 21);
      check("t5_done_cyc", done_cyc - start_cyc, 146);

      // start re-pulsed in GAP and in WAIT is ignored
      dc = done_count;
      do_start(2'b11, 2'b00, 2'b00, 1'b1);
      wait_until(start_cyc + 5);
      pulse_start();
      wait_until(start_cyc + 40);
      pulse_start();
      wait_done(600);
      repeat (30) @(negedge ACLK);
      check("t6_one_seq_done", done_count - dc, 1);
      check("t6_done_cyc", done_cyc - start_cyc, 146);
      check("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
